// File: rtl/tpu_mmio_host_seq_pkg.sv
// Shared constants, FSM state type and sizing helpers for the tpuv1 MMIO host sequencer.
// Addresses are byte offsets on the tpuv1 MMIO map; one MMIO word covers 8 address units.
package tpu_mmio_pkg;

  localparam int A_BASE      = 32'h0100;
  localparam int B_BASE      = 32'h0200;
  localparam int C_BASE      = 32'h0300;
  localparam int MATMUL_ADDR = 32'h0400;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    TRIG,
    WAIT,
    READ,
    DRAIN
  } state_t;

  // MMIO words needed to carry one row of C
  function automatic int c_words_per_row(int dim, int bits_c, int dataw);
    return dim * bits_c / dataw;
  endfunction

  function automatic int word_addr(int base, int idx);
    return base + 8 * idx;
  endfunction

endpackage

// File: rtl/tpu_mmio_host_seq_if.sv
// Host-side operand/result streams plus the tpuv1 MMIO bus driven by the sequencer.
// master = the sequencer, slave = host front end together with tpuv1.
interface tpu_mmio_host_seq_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             start;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] tpu_din;
  logic             r_w;
  logic [DATAW-1:0] tpu_dout;

  modport master (
    input  start, in_data, in_valid, out_ready, tpu_dout,
    output in_ready, out_data, out_valid, busy, done, addr, tpu_din, r_w
  );

  modport slave (
    output start, in_data, in_valid, out_ready, tpu_dout,
    input  in_ready, out_data, out_valid, busy, done, addr, tpu_din, r_w
  );
endinterface

// File: rtl/tpu_mmio_host_seq.sv
// Runs clear C / load A,B / MATMUL / wait / read C on tpuv1; accepted operands hit the bus one cycle later.
// Result stream obeys valid/ready: while a word is held the C read address is held too.
module tpu_mmio_host_seq
  import tpu_mmio_pkg::*;
#(
  parameter int BITS_AB     = 8,
  parameter int BITS_C      = 16,
  parameter int DIM         = 8,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int WAIT_CYCLES = DIM * 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tpu_mmio_host_seq_if.master io
);

  localparam int CW    = c_words_per_row(DIM, BITS_C, DATAW);
  localparam int NC    = DIM * CW;
  localparam int NIN   = 2 * DIM;
  localparam int CNTW  = $clog2(NIN + 1);
  localparam int WCW   = $clog2(WAIT_CYCLES + 1);
  localparam int ROW_W = DIM * BITS_AB;

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [WCW-1:0]   wcnt;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] din_q;
  logic             rw_q;
  logic             in_ready_q;
  logic [DATAW-1:0] out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  logic in_fire;
  logic out_take;

  assign in_fire  = in_ready_q && io.in_valid;
  assign out_take = !out_valid_q || io.out_ready;

  assign io.in_ready  = in_ready_q;
  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.addr      = addr_q;
  assign io.tpu_din   = din_q;
  assign io.r_w       = rw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wcnt        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rw_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // bus idles unless a state below issues an access this cycle
      addr_q <= '0;
      din_q  <= '0;
      rw_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            state  <= CLR;
            busy_q <= 1'b1;
            cnt    <= '0;
          end
        end
        CLR: begin
          addr_q <= ADDRW'(word_addr(C_BASE, int'(cnt)));
          rw_q   <= 1'b1;
          if (cnt == CNTW'(NC - 1)) begin
            cnt        <= '0;
            in_ready_q <= 1'b1;
            state      <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD: begin
          if (in_fire) begin
            // even words are A rows, odd words are B rows
            addr_q <= ADDRW'(word_addr(cnt[0] ? B_BASE : A_BASE, int'(cnt >> 1)));
            din_q  <= DATAW'(io.in_data[ROW_W-1:0]);
            rw_q   <= 1'b1;
            if (cnt == CNTW'(NIN - 1)) begin
              cnt        <= '0;
              in_ready_q <= 1'b0;
              state      <= TRIG;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        TRIG: begin
          addr_q <= ADDRW'(MATMUL_ADDR);
          rw_q   <= 1'b1;
          wcnt   <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (wcnt == WCW'(WAIT_CYCLES)) begin
            addr_q <= ADDRW'(C_BASE);
            cnt    <= '0;
            state  <= READ;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        READ: begin
          if (out_take) begin
            out_data_q  <= io.tpu_dout;
            out_valid_q <= 1'b1;
            if (cnt == CNTW'(NC - 1)) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt    <= cnt + 1'b1;
              addr_q <= ADDRW'(word_addr(C_BASE, int'(cnt) + 1));
            end
          end else begin
            addr_q <= addr_q;
          end
        end
        DRAIN: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_mmio_host_seq.sv
// Bench for tpu_mmio_host_seq: behavioural tpuv1 memory plus expected-write and expected-result
// queues derived from the operand matrices; one negedge monitor compares the DUT every cycle.
module tb_tpu_mmio_host_seq;

  localparam int WAIT_CYCLES = 32;

  typedef struct packed {
    logic [15:0] a;
    logic [63:0] d;
  } wr_t;

  logic clk;
  logic rst_n;

  tpu_mmio_host_seq_if #(.ADDRW(16), .DATAW(64)) bus ();

  tpu_mmio_host_seq #(
    .BITS_AB(8), .BITS_C(16), .DIM(8), .ADDRW(16), .DATAW(64), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] a_rows[8];
  logic [63:0] b_rows[8];
  wr_t         exp_w[$];
  logic [63:0] exp_r[$];

  logic [63:0] amem[8];
  logic [63:0] bmem[8];
  logic [63:0] cmem[16];

  int cyc = 0;
  int trig_cyc = -1;
  int first_rd = -1;
  int done_cnt = 0;
  int words = 0;
  bit prev_rdy = 0;
  bit prev_acc = 0;
  bit prev_hold = 0;
  logic [63:0] prev_dat = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // tpuv1 stand-in: word-addressed A/B/C storage, MATMUL accumulates A*B into C
  always @(posedge clk) begin
    if (rst_n && bus.r_w) begin
      if (bus.addr[15:7] == 9'd6) cmem[bus.addr[6:3]] <= bus.tpu_din;
      else if (bus.addr[15:6] == 10'd4) amem[bus.addr[5:3]] <= bus.tpu_din;
      else if (bus.addr[15:6] == 10'd8) bmem[bus.addr[5:3]] <= bus.tpu_din;
      else if (bus.addr == 16'h0400) begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < 8; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < 8; k++)
              s += int'(amem[i][8*k +: 8]) * int'(bmem[k][8*j +: 8]);
            cmem[2*i + j/4][16*(j%4) +: 16] <= cmem[2*i + j/4][16*(j%4) +: 16] + 16'(s);
          end
        end
      end
    end
  end

  assign bus.tpu_dout = (bus.addr[15:7] == 9'd6) ? cmem[bus.addr[6:3]] : 64'h0;

  // Expected bus writes and result words straight from the operand matrices
  task automatic build_exp();
    wr_t w;
    exp_w.delete();
    exp_r.delete();
    for (int r = 0; r < 16; r++) begin
      w.a = 16'(16'h0300 + 8*r); w.d = '0; exp_w.push_back(w);
    end
    for (int i = 0; i < 8; i++) begin
      w.a = 16'(16'h0100 + 8*i); w.d = a_rows[i]; exp_w.push_back(w);
      w.a = 16'(16'h0200 + 8*i); w.d = b_rows[i]; exp_w.push_back(w);
    end
    w.a = 16'h0400; w.d = '0; exp_w.push_back(w);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] lo, hi;
      for (int j = 0; j < 8; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 8; k++)
          s += int'(a_rows[i][8*k +: 8]) * int'(b_rows[k][8*j +: 8]);
        if (j < 4) lo[16*j +: 16] = 16'(s);
        else       hi[16*(j-4) +: 16] = 16'(s);
      end
      exp_r.push_back(lo);
      exp_r.push_back(hi);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 0; prev_acc = 0; prev_hold = 0;
    end else begin
      if (bus.r_w) begin
        if (exp_w.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_write: got write %h<=%h, required no write", bus.addr, bus.tpu_din);
        end else begin
          wr_t w;
          w = exp_w.pop_front();
          chk("wr_addr", 64'(bus.addr), 64'(w.a));
          chk("wr_data", bus.tpu_din, w.d);
        end
        if (bus.addr == 16'h0400) trig_cyc = cyc;
      end else begin
        chk("idle_din", bus.tpu_din, 64'h0);
        if (bus.addr != 16'h0 && first_rd < 0) first_rd = cyc;
      end
      if (prev_rdy) chk("load_wr_next_cycle", 64'(bus.r_w), 64'(prev_acc));
      prev_rdy = bus.in_ready;
      prev_acc = bus.in_valid && bus.in_ready;
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.out_valid), 64'h1);
        chk("hold_data", bus.out_data, prev_dat);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_dat  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        words++;
        if (exp_r.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_result: got %h, required no word", bus.out_data);
        end else begin
          chk("c_word", bus.out_data, exp_r.pop_front());
        end
      end
      if (bus.done) done_cnt++;
    end
    cyc++;
  end

  task automatic feed(input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    bit ph = 1'b1;
    bit acc;
    while (i < n && guard < 300) begin
      bus.in_data  = (i % 2 == 0) ? a_rows[i/2] : b_rows[i/2];
      bus.in_valid = gaps ? ph : 1'b1;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      ph = ~ph;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    if (i < n) begin
      tests++; fails++;
      $display("FAIL feed_timeout: accepted %0d words, required %0d", i, n);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"},      64'(bus.addr), 64'h0);
    chk({tag, "_r_w"},       64'(bus.r_w), 64'h0);
    chk({tag, "_din"},       bus.tpu_din, 64'h0);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'h0);
    chk({tag, "_busy"},      64'(bus.busy), 64'h0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
    chk({tag, "_out_data"},  bus.out_data, 64'h0);
    chk({tag, "_done"},      64'(bus.done), 64'h0);
  endtask

  task automatic run_txn(input bit gaps, input bit stall, input bit busy_start);
    int g;
    build_exp();
    done_cnt = 0; words = 0; first_rd = -1; trig_cyc = -1;
    bus.out_ready = stall ? 1'b0 : 1'b1;
    pulse_start();
    chk("busy_after_start", 64'(bus.busy), 64'h1);
    feed(16, gaps);
    if (busy_start) begin
      g = 0;
      do begin @(negedge clk); g++; end while (!(bus.r_w && bus.addr == 16'h0400) && g < 100);
      repeat (3) @(negedge clk);
      pulse_start();
    end
    if (stall) begin
      g = 0;
      do begin @(negedge clk); g++; end while (!bus.out_valid && g < 300);
      for (int s = 0; s < 5; s++) begin
        if (s > 0) @(negedge clk);
        chk("stall_addr", 64'(bus.addr), 64'h308);
        chk("stall_valid", 64'(bus.out_valid), 64'h1);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
    end
    g = 0;
    while (!bus.done && g < 1000) begin @(negedge clk); g++; end
    if (g >= 1000) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles", g);
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'h1);
    chk("words_delivered", 64'(words), 64'd16);
    chk("writes_left", 64'(exp_w.size()), 64'h0);
    chk("results_left", 64'(exp_r.size()), 64'h0);
    chk("read_latency", 64'(first_rd - trig_cyc), 64'(WAIT_CYCLES + 1));
    chk("busy_after_done", 64'(bus.busy), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) cmem[i] = '0;
    for (int i = 0; i < 8; i++) begin amem[i] = '0; bmem[i] = '0; end
    #12;
    check_zero("reset");
    #15 rst_n = 1'b1;

    // A = identity, B row r = r+1 in every element
    for (int r = 0; r < 8; r++) begin
      a_rows[r] = 64'h1 << (8*r);
      for (int k = 0; k < 8; k++) b_rows[r][8*k +: 8] = 8'(r + 1);
    end
    build_exp();
    chk("pin_c0_lo", exp_r[0], 64'h0001_0001_0001_0001);
    chk("pin_c2_hi", exp_r[5], 64'h0003_0003_0003_0003);
    chk("pin_c7_hi", exp_r[15], 64'h0008_0008_0008_0008);
    chk("pin_first_load", 64'(exp_w[16].a), 64'h100);
    chk("pin_first_b", 64'(exp_w[17].a), 64'h200);
    chk("pin_trig", 64'(exp_w[32].a), 64'h400);

    run_txn(1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b0, 1'b1);

    // Reset in the middle of LOAD, after the fifth operand word is on the bus
    build_exp();
    bus.out_ready = 1'b1;
    pulse_start();
    feed(5, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_w.delete();
    exp_r.delete();

    for (int r = 0; r < 8; r++) begin
      a_rows[r] = {8{8'h01}};
      b_rows[r] = {8{8'h01}};
    end
    build_exp();
    chk("pin_ones_c2_hi", exp_r[5], 64'h0008_0008_0008_0008);
    run_txn(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tpu_mmio_host_seq.md
Name: tpu_mmio_host_seq

Overview:
- Hardware initiator for the tpuv1 MMIO interface (addr / dataIn / r_w / dataOut).
- Performs in RTL the full matmul transaction sequence that the bench currently does by hand:
  - clear C;
  - stream A and B rows in;
  - trigger MATMUL;
  - wait;
  - read C back out as a 64-bit result stream.
- Sits between the CCI-P MMIO/DMA front end and tpuv1, so the host supplies operands and collects results without per-word address handling.

Parameters:
- BITS_AB, 8, A/B element width
- BITS_C, 16, C element width
- DIM, 8, array dimension (rows of A, B, C)
- ADDRW, 16, MMIO address width
- DATAW, 64, MMIO data width; must equal DIM*BITS_AB
- WAIT_CYCLES, 32 (DIM*4), cycles between MATMUL write and first C read

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transaction when idle
- in_data  in  DATAW  operand word
- in_valid  in  1  operand word valid
- in_ready  out  1  operand word accepted when in_valid && in_ready
- out_data  out  DATAW  C result word
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result word
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result word is accepted
- addr  out  ADDRW  tpuv1 address
- tpu_din  out  DATAW  drives tpuv1 dataIn
- r_w  out  1  1 = write, 0 = read
- tpu_dout  in  DATAW  tpuv1 dataOut; combinational from addr, sampled in the same cycle

Behaviour:
- Reset values:
  - all outputs are 0;
  - FSM goes to IDLE;
  - counters are cleared.
- Reset is async; when asserted mid-operation, r_w drops to 0 immediately and no further MMIO write occurs.
- Address map:
  - A row r at 0x100+8r; B row r at 0x200+8r;
  - C row r lo half at 0x300+16r, hi half at 0x308+16r;
  - MATMUL trigger is a write to 0x400 (data don't-care, driven 0).
- CW = DIM*BITS_C/DATAW = 2 words per C row.
- Idle bus: whenever no access is issued, addr=0, r_w=0, tpu_din=0. All bus outputs are registered.
- FSM states and transitions:
  - IDLE: on start go to CLR; start while busy is ignored.
  - CLR: DIM*CW consecutive write cycles of 0 to 0x300, 0x308, ..., 0x378, one per cycle, then go to LOAD.
  - LOAD: 2*DIM words in the order A0,B0,A1,B1,...
    - in_ready=1 only in LOAD.
    - Each accepted word is written to tpuv1 on the next cycle (addr/tpu_din/r_w=1 registered). An accepted A word goes to the next A address; an accepted B word goes to the next B address.
    - Cycles with no accepted word produce r_w=0, addr=0.
    - After the 2*DIM-th word is written, go to TRIG.
  - TRIG: one cycle with addr=0x400, r_w=1, then go to WAIT.
  - WAIT: counter runs WAIT_CYCLES cycles with the bus idle, then go to READ.
  - READ: drive C addresses in order 0x300, 0x308, ..., 0x378 with r_w=0.
    - At the clock edge: if !out_valid || out_ready, capture tpu_dout into out_data, set out_valid, and advance the address.
    - Otherwise hold addr and out_data stable.
    - After the last capture, go to DRAIN.
  - DRAIN: wait until the final word is accepted, then pulse done and go to IDLE.
- out_valid/out_data follow the standard valid/ready rule: out_data is stable while out_valid && !out_ready.
- Output word order: C0 lo, C0 hi, C1 lo, ... C7 hi. Within a word, element k occupies bits [16k+15:16k].
- Input word packing: element k occupies bits [8k+7:8k].
- No arithmetic is performed on data; counters are sized $clog2(2*DIM+1) and $clog2(WAIT_CYCLES+1).

Decomposition:
- Package tpu_mmio_pkg holds:
  - address constants A_BASE=0x100, B_BASE=0x200, C_BASE=0x300, MATMUL_ADDR=0x400;
  - the state enum (IDLE, CLR, LOAD, TRIG, WAIT, READ, DRAIN);
  - the helper function computing CW.
- No sub-module: a single FSM plus counters.

Test Plan:
- Reset: assert rst_n=0 mid-clock → all outputs 0 asynchronously; busy=0, in_ready=0.
- Identity test:
  - Stimulus: A=I, B row r = {8{r+1}}, continuous in_valid, out_ready=1.
  - Required bus trace: 16 zero writes 0x300..0x378, then writes at 0x100, 0x200, 0x108, ..., 0x238, then a 0x400 write.
  - Required timing and output: first C read exactly WAIT_CYCLES+1 cycles after the 0x400 write; C row r elements all equal r+1; done pulses once.
- Input gaps: in_valid toggled every other cycle → same address/data write sequence, r_w=0 in gap cycles, identical results.
- Output backpressure: out_ready held low 5 cycles at the first word → addr held at 0x308 (second word pending), out_data stable, exactly 16 words delivered, none duplicated.
- Start while busy: pulse start during WAIT → ignored, no extra CLR writes.
- Reset mid-LOAD after word 5, then a fresh start → sequence restarts with CLR at 0x300; results correct with all-ones A and B (every C element = 8).
